// File: rtl/grf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter_pkg
//  Description : Shared widths, constants and entry type for the GRF
//                write-back arbiter and its result buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package grf_wb_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // One buffered long-latency result (the live bit is kept separately)
   typedef struct packed {
      logic [REG_W-1:0]  number;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] pc;
   } wb_entry_t;

   // $0 is hard-wired, so writes to it carry no architectural effect
   function automatic logic is_real_reg(input logic [REG_W-1:0] n);
      return n != REG_ZERO;
   endfunction

endpackage
`default_nettype wire

// File: rtl/grf_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter_wb_fifo
//  Description : Circular buffer of long-latency results. Each entry carries
//                a live bit that is cleared when a younger pipeline write to
//                the same register makes the buffered value obsolete.
//  Revision    : 1.0  initial release
// ============================================================================
module grf_wb_arbiter_wb_fifo
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  wb_entry_t              push_entry_i,
   input  logic                   push_live_i,
   input  logic                   pop_i,
   input  logic                   squash_i,
   input  logic [REG_W-1:0]       squash_number_i,
   output wb_entry_t              head_entry_o,
   output logic                   head_live_o,
   output logic [AW:0]            count_o,
   output logic [DEPTH-1:0]       live_o,
   output logic [DEPTH*REG_W-1:0] numbers_o
);

   wb_entry_t        entry_q [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [DEPTH-1:0] live_d;
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;

   // Per-entry live update: pop and squash clear, a push writes the new flag.
   // Free slots stay non-live, so the busy compare can scan every slot.
   always_comb begin
      live_d = live_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (pop_i && (head_q == AW'(i)))
            live_d[i] = 1'b0;
         if (squash_i && (entry_q[i].number == squash_number_i))
            live_d[i] = 1'b0;
         if (push_i && (tail_q == AW'(i)))
            live_d[i] = push_live_i;
      end
   end

   // Occupancy: push and pop may coincide and then cancel out
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and live bits
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
      end else begin
         live_q  <= live_d;
         count_q <= count_d;
         if (push_i)
            tail_q <= tail_q + 1'b1;
         if (pop_i)
            head_q <= head_q + 1'b1;
      end
   end

   // Payload storage needs no reset; the live bits gate every use of it
   always_ff @(posedge clk) begin
      if (push_i)
         entry_q[tail_q] <= push_entry_i;
   end

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_num
         assign numbers_o[g*REG_W +: REG_W] = entry_q[g].number;
      end
   endgenerate

   assign head_entry_o = entry_q[head_q];
   assign head_live_o  = live_q[head_q];
   assign count_o      = count_q;
   assign live_o       = live_q;

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wb_arbiter
//  Description : Merges the W-stage write stream and buffered long-latency
//                results onto the single GRF write port, with pending-write
//                busy flags for decode.
//  Revision    : 1.0  initial release
// ============================================================================
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_we,
   input  logic [REG_W-1:0]  pipe_number,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic [DATA_W-1:0] pipe_pc,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [REG_W-1:0]  lu_number,
   input  logic [DATA_W-1:0] lu_data,
   input  logic [DATA_W-1:0] lu_pc,
   output logic              grf_we,
   output logic [REG_W-1:0]  grf_number,
   output logic [DATA_W-1:0] grf_data,
   output logic [DATA_W-1:0] grf_pc,
   input  logic [REG_W-1:0]  query_number1,
   input  logic [REG_W-1:0]  query_number2,
   output logic              query_busy1,
   output logic              query_busy2,
   output logic [AW:0]       count
);

   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

   logic                   w_pipe_active;
   logic                   w_head_valid;
   logic                   w_push;
   logic                   w_push_live;
   logic                   w_pop;
   wb_entry_t              w_push_entry;
   wb_entry_t              w_head_entry;
   logic                   w_head_live;
   logic [AW:0]            w_count;
   logic [DEPTH-1:0]       w_live;
   logic [DEPTH*REG_W-1:0] w_numbers;

   assign w_pipe_active = pipe_we && is_real_reg(pipe_number) && !reset;
   assign w_head_valid  = (w_count != '0) && !reset;
   assign lu_ready      = (w_count < c_depth) && !reset;

   // Results for $0 are acknowledged but never buffered
   assign w_push       = lu_valid && lu_ready && is_real_reg(lu_number);
   // A same-cycle pipeline write to the same register is younger, so the
   // incoming result is born already obsolete
   assign w_push_live  = !(w_pipe_active && (lu_number == pipe_number));
   assign w_push_entry = '{number: lu_number, data: lu_data, pc: lu_pc};

   // A dead head always leaves; a live head leaves only when the port is free
   assign w_pop = w_head_valid && (!w_head_live || !w_pipe_active);

   grf_wb_arbiter_wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk             (clk),
      .reset           (reset),
      .push_i          (w_push),
      .push_entry_i    (w_push_entry),
      .push_live_i     (w_push_live),
      .pop_i           (w_pop),
      .squash_i        (w_pipe_active),
      .squash_number_i (pipe_number),
      .head_entry_o    (w_head_entry),
      .head_live_o     (w_head_live),
      .count_o         (w_count),
      .live_o          (w_live),
      .numbers_o       (w_numbers)
   );

   // Write-port mux: pipeline first, then a live buffered head
   always_comb begin
      grf_we     = 1'b0;
      grf_number = '0;
      grf_data   = '0;
      grf_pc     = '0;
      if (w_pipe_active) begin
         grf_we     = 1'b1;
         grf_number = pipe_number;
         grf_data   = pipe_data;
         grf_pc     = pipe_pc;
      end else if (w_head_valid && w_head_live) begin
         grf_we     = 1'b1;
         grf_number = w_head_entry.number;
         grf_data   = w_head_entry.data;
         grf_pc     = w_head_entry.pc;
      end
   end

   // Busy flags scan live entries as they stand before this edge
   always_comb begin
      query_busy1 = 1'b0;
      query_busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_live[i] && (w_numbers[i*REG_W +: REG_W] == query_number1))
            query_busy1 = 1'b1;
         if (w_live[i] && (w_numbers[i*REG_W +: REG_W] == query_number2))
            query_busy2 = 1'b1;
      end
      if (!is_real_reg(query_number1) || reset)
         query_busy1 = 1'b0;
      if (!is_real_reg(query_number2) || reset)
         query_busy2 = 1'b0;
   end

   assign count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_wb_arbiter
//  Description : Self-checking bench for grf_wb_arbiter with a queue-based
//                reference model of the buffer and arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_grf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_we;
   logic [4:0]  pipe_number;
   logic [31:0] pipe_data;
   logic [31:0] pipe_pc;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_number;
   logic [31:0] lu_data;
   logic [31:0] lu_pc;
   logic        grf_we;
   logic [4:0]  grf_number;
   logic [31:0] grf_data;
   logic [31:0] grf_pc;
   logic [4:0]  query_number1;
   logic [4:0]  query_number2;
   logic        query_busy1;
   logic        query_busy2;
   logic [2:0]  count;

   grf_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .pipe_we       (pipe_we),
      .pipe_number   (pipe_number),
      .pipe_data     (pipe_data),
      .pipe_pc       (pipe_pc),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_number     (lu_number),
      .lu_data       (lu_data),
      .lu_pc         (lu_pc),
      .grf_we        (grf_we),
      .grf_number    (grf_number),
      .grf_data      (grf_data),
      .grf_pc        (grf_pc),
      .query_number1 (query_number1),
      .query_number2 (query_number2),
      .query_busy1   (query_busy1),
      .query_busy2   (query_busy2),
      .count         (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  num;
      logic [31:0] data;
      logic [31:0] pc;
      bit          live;
   } ent_t;

   ent_t        m_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   // Expected and observed values for the cycle just evaluated
   logic        exp_we, obs_we;
   logic [4:0]  exp_num, obs_num;
   logic [31:0] exp_data, obs_data;
   logic [31:0] exp_pc, obs_pc;
   logic        exp_ready, obs_ready;
   logic [2:0]  exp_count, obs_count;
   logic        exp_b1, obs_b1, exp_b2, obs_b2;

   // One clock cycle: drive, evaluate model, sample DUT mid-cycle, advance
   task automatic tick(input logic r, input logic pwe, input logic [4:0] pn,
                       input logic [31:0] pd, input logic lv, input logic [4:0] ln,
                       input logic [31:0] ld, input logic [4:0] q1, input logic [4:0] q2);
      logic pa;
      logic pop;
      logic [31:0] pp;
      logic [31:0] lp;
      pp = pd ^ 32'h5A5A_0000;
      lp = ld ^ 32'h0000_A5A5;
      @(negedge clk);
      reset = r; pipe_we = pwe; pipe_number = pn; pipe_data = pd; pipe_pc = pp;
      lu_valid = lv; lu_number = ln; lu_data = ld; lu_pc = lp;
      query_number1 = q1; query_number2 = q2;
      #1;
      pa        = !r && pwe && (pn != 5'd0);
      exp_ready = !r && (m_q.size() < 4);
      exp_count = 3'(m_q.size());
      exp_we = 1'b0; exp_num = '0; exp_data = '0; exp_pc = '0;
      if (pa) begin
         exp_we = 1'b1; exp_num = pn; exp_data = pd; exp_pc = pp;
      end else if (!r && m_q.size() > 0 && m_q[0].live) begin
         exp_we = 1'b1; exp_num = m_q[0].num; exp_data = m_q[0].data; exp_pc = m_q[0].pc;
      end
      exp_b1 = 1'b0; exp_b2 = 1'b0;
      foreach (m_q[i]) begin
         if (m_q[i].live && m_q[i].num == q1) exp_b1 = 1'b1;
         if (m_q[i].live && m_q[i].num == q2) exp_b2 = 1'b1;
      end
      if (r || q1 == 5'd0) exp_b1 = 1'b0;
      if (r || q2 == 5'd0) exp_b2 = 1'b0;
      obs_we = grf_we; obs_num = grf_number; obs_data = grf_data; obs_pc = grf_pc;
      obs_ready = lu_ready; obs_count = count; obs_b1 = query_busy1; obs_b2 = query_busy2;
      @(posedge clk);
      if (r) begin
         m_q.delete();
      end else begin
         pop = (m_q.size() > 0) && (!m_q[0].live || !pa);
         if (pop) void'(m_q.pop_front());
         if (pa) foreach (m_q[i]) if (m_q[i].num == pn) m_q[i].live = 1'b0;
         if (lv && exp_ready && ln != 5'd0)
            m_q.push_back('{num: ln, data: ld, pc: lp, live: !(pa && ln == pn)});
      end
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 0, 0, 0, 0, 5, 6);
      tick(1, 1, 7, 32'h77, 1, 3, 32'h33, 5, 6);
      n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", obs_we); end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", obs_ready); end
      n_cmp++; if (obs_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", obs_count); end
      tick(0, 0, 0, 0, 0, 0, 0, 5, 6);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", obs_ready); end
      n_cmp++; if (obs_b1 !== 1'b0 || obs_b2 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b%b want 00", obs_b1, obs_b2); end
   endtask

   task automatic test_idle_drain();
      tick(0, 0, 0, 0, 1, 5, 32'h1234, 5, 0);
      n_cmp++; if (obs_b1 !== 1'b0) begin n_fail++; $display("FAIL drain_busy_pre got %b want 0", obs_b1); end
      tick(0, 0, 0, 0, 0, 0, 0, 5, 0);
      n_cmp++; if (obs_we !== 1'b1 || obs_num !== 5'd5 || obs_data !== 32'h1234) begin
         n_fail++; $display("FAIL drain_write got we=%b $%0d %h want we=1 $5 00001234", obs_we, obs_num, obs_data); end
      n_cmp++; if (obs_pc !== (32'h1234 ^ 32'h0000_A5A5)) begin n_fail++; $display("FAIL drain_pc got %h want %h", obs_pc, 32'h1234 ^ 32'h0000_A5A5); end
      n_cmp++; if (obs_b1 !== 1'b1 || obs_count !== 3'd1) begin n_fail++; $display("FAIL drain_busy got busy=%b cnt=%0d want 1 1", obs_b1, obs_count); end
      tick(0, 0, 0, 0, 0, 0, 0, 5, 0);
      n_cmp++; if (obs_we !== 1'b0 || obs_b1 !== 1'b0 || obs_count !== 3'd0) begin
         n_fail++; $display("FAIL drain_after got we=%b busy=%b cnt=%0d want 0 0 0", obs_we, obs_b1, obs_count); end
   endtask

   task automatic test_pipe_priority();
      tick(0, 1, 7, 32'h70, 1, 3, 32'h30, 3, 4);
      tick(0, 1, 7, 32'h71, 1, 4, 32'h40, 3, 4);
      n_cmp++; if (obs_num !== 5'd7 || obs_data !== 32'h71 || obs_b1 !== 1'b1) begin
         n_fail++; $display("FAIL prio_pipe1 got $%0d %h b=%b want $7 00000071 1", obs_num, obs_data, obs_b1); end
      tick(0, 1, 7, 32'h72, 0, 0, 0, 3, 4);
      n_cmp++; if (obs_num !== 5'd7 || obs_count !== 3'd2) begin n_fail++; $display("FAIL prio_pipe2 got $%0d cnt=%0d want $7 2", obs_num, obs_count); end
      tick(0, 0, 0, 0, 0, 0, 0, 3, 4);
      n_cmp++; if (obs_we !== 1'b1 || obs_num !== 5'd3 || obs_data !== 32'h30) begin
         n_fail++; $display("FAIL prio_first got we=%b $%0d %h want 1 $3 00000030", obs_we, obs_num, obs_data); end
      tick(0, 0, 0, 0, 0, 0, 0, 3, 4);
      n_cmp++; if (obs_num !== 5'd4 || obs_data !== 32'h40 || obs_b1 !== 1'b0 || obs_b2 !== 1'b1) begin
         n_fail++; $display("FAIL prio_second got $%0d %h b=%b%b want $4 00000040 01", obs_num, obs_data, obs_b1, obs_b2); end
      tick(0, 0, 0, 0, 0, 0, 0, 3, 4);
      n_cmp++; if (obs_we !== 1'b0 || obs_count !== 3'd0) begin n_fail++; $display("FAIL prio_empty got we=%b cnt=%0d want 0 0", obs_we, obs_count); end
   endtask

   task automatic test_squash();
      tick(0, 1, 9, 32'h99, 1, 8, 32'hAAAA, 8, 0);
      tick(0, 1, 8, 32'hBBBB, 0, 0, 0, 8, 0);
      n_cmp++; if (obs_b1 !== 1'b1 || obs_num !== 5'd8 || obs_data !== 32'hBBBB) begin
         n_fail++; $display("FAIL squash_pipe got b=%b $%0d %h want 1 $8 0000bbbb", obs_b1, obs_num, obs_data); end
      tick(0, 0, 0, 0, 0, 0, 0, 8, 0);
      n_cmp++; if (obs_we !== 1'b0 || obs_b1 !== 1'b0 || obs_count !== 3'd1) begin
         n_fail++; $display("FAIL squash_dead got we=%b b=%b cnt=%0d want 0 0 1", obs_we, obs_b1, obs_count); end
      // same-cycle enqueue of a register the pipe also writes
      tick(0, 1, 8, 32'hCCCC, 1, 8, 32'hDDDD, 8, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 8, 0);
      n_cmp++; if (obs_we !== 1'b0 || obs_b1 !== 1'b0 || obs_count !== 3'd1) begin
         n_fail++; $display("FAIL squash_same got we=%b b=%b cnt=%0d want 0 0 1", obs_we, obs_b1, obs_count); end
      tick(0, 0, 0, 0, 0, 0, 0, 8, 0);
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++)
         tick(0, 1, 1, 32'h11, 1, 5'(10 + i), 32'(32'h100 + i), 10, 13);
      tick(0, 1, 1, 32'h11, 1, 14, 32'h200, 10, 13);
      n_cmp++; if (obs_ready !== 1'b0 || obs_count !== 3'd4) begin n_fail++; $display("FAIL full_ready got rdy=%b cnt=%0d want 0 4", obs_ready, obs_count); end
      tick(0, 0, 0, 0, 1, 14, 32'h200, 10, 13);
      n_cmp++; if (obs_ready !== 1'b0 || obs_num !== 5'd10 || obs_data !== 32'h100) begin
         n_fail++; $display("FAIL full_pop got rdy=%b $%0d %h want 0 $10 00000100", obs_ready, obs_num, obs_data); end
      tick(0, 0, 0, 0, 1, 14, 32'h200, 14, 13);
      n_cmp++; if (obs_ready !== 1'b1 || obs_count !== 3'd3 || obs_num !== 5'd11) begin
         n_fail++; $display("FAIL full_accept got rdy=%b cnt=%0d $%0d want 1 3 $11", obs_ready, obs_count, obs_num); end
      tick(0, 0, 0, 0, 0, 0, 0, 14, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 14, 0);
      tick(0, 0, 0, 0, 0, 0, 0, 14, 0);
      n_cmp++; if (obs_num !== 5'd14 || obs_data !== 32'h200 || obs_b1 !== 1'b1) begin
         n_fail++; $display("FAIL full_fifth got $%0d %h b=%b want $14 00000200 1", obs_num, obs_data, obs_b1); end
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_zero_reg();
      tick(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", obs_ready); end
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (obs_count !== 3'd0 || obs_we !== 1'b0) begin n_fail++; $display("FAIL zero_drop got cnt=%0d we=%b want 0 0", obs_count, obs_we); end
      tick(0, 1, 2, 32'h22, 1, 6, 32'h66, 0, 6);
      tick(0, 1, 0, 32'hEEEE, 0, 0, 0, 0, 6);
      n_cmp++; if (obs_we !== 1'b1 || obs_num !== 5'd6 || obs_data !== 32'h66 || obs_b2 !== 1'b1) begin
         n_fail++; $display("FAIL zero_pipe got we=%b $%0d %h b=%b want 1 $6 00000066 1", obs_we, obs_num, obs_data, obs_b2); end
      tick(0, 0, 0, 0, 0, 0, 0, 0, 6);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++)
         tick(0, 1, 1, 32'h1, 1, 5'(20 + i), 32'(32'h300 + i), 20, 22);
      tick(1, 0, 0, 0, 0, 0, 0, 20, 22);
      n_cmp++; if (obs_we !== 1'b0 || obs_ready !== 1'b0 || obs_count !== 3'd3 || obs_b1 !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_during got we=%b rdy=%b cnt=%0d b=%b want 0 0 3 0", obs_we, obs_ready, obs_count, obs_b1); end
      tick(0, 0, 0, 0, 0, 0, 0, 20, 22);
      n_cmp++; if (obs_we !== 1'b0 || obs_count !== 3'd0 || obs_b2 !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_after got we=%b cnt=%0d b=%b want 0 0 0", obs_we, obs_count, obs_b2); end
      tick(0, 0, 0, 0, 0, 0, 0, 20, 22);
      n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale got we=%b want 0", obs_we); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
              $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         n_cmp++;
         if (obs_we !== exp_we || (exp_we && (obs_num !== exp_num || obs_data !== exp_data || obs_pc !== exp_pc))) begin
            n_fail++;
            $display("FAIL rand_grf cyc=%0d got we=%b $%0d %h %h want we=%b $%0d %h %h",
                     c, obs_we, obs_num, obs_data, obs_pc, exp_we, exp_num, exp_data, exp_pc);
         end
         n_cmp++;
         if (obs_ready !== exp_ready || obs_count !== exp_count) begin
            n_fail++;
            $display("FAIL rand_occ cyc=%0d got rdy=%b cnt=%0d want rdy=%b cnt=%0d", c, obs_ready, obs_count, exp_ready, exp_count);
         end
         n_cmp++;
         if (obs_b1 !== exp_b1 || obs_b2 !== exp_b2) begin
            n_fail++;
            $display("FAIL rand_busy cyc=%0d got %b%b want %b%b", c, obs_b1, obs_b2, exp_b1, exp_b2);
         end
      end
   endtask

   initial begin
      reset = 1'b1; pipe_we = 1'b0; pipe_number = '0; pipe_data = '0; pipe_pc = '0;
      lu_valid = 1'b0; lu_number = '0; lu_data = '0; lu_pc = '0;
      query_number1 = '0; query_number2 = '0;
      test_reset();
      test_idle_drain();
      test_pipe_priority();
      test_squash();
      test_full();
      test_zero_reg();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
